// File: rtl/sparam_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// sparam_sweep_ctrl_if
// Bundles the bus signals between the S-parameter sweep controller and the
// rest of the measurement chain:
//   excitation : exc_en, exc_port        (controller -> source switch)
//   receiver   : rx_sel                  (controller -> receiver switch)
//                rx_valid, rx_data       (receiver   -> controller)
//   results    : res_valid, res_row, res_col, res_data (controller -> sink)
//                res_ready                             (sink -> controller)
// The master modport is the controller side; slave is the environment side.
// ---------------------------------------------------------------------------
interface sparam_sweep_ctrl_if #(
    parameter int DW = 16
);
    logic          exc_en;
    logic [1:0]    exc_port;
    logic [1:0]    rx_sel;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          res_valid;
    logic          res_ready;
    logic [1:0]    res_row;
    logic [1:0]    res_col;
    logic [DW-1:0] res_data;

    modport master (
        output exc_en, exc_port, rx_sel,
        output res_valid, res_row, res_col, res_data,
        input  rx_valid, rx_data, res_ready
    );

    modport slave (
        input  exc_en, exc_port, rx_sel,
        input  res_valid, res_row, res_col, res_data,
        output rx_valid, rx_data, res_ready
    );
endinterface

// File: rtl/sparam_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// sparam_sweep_ctrl
// Sequences a full NPORTS x NPORTS S-parameter magnitude sweep. For each
// excitation port j the source is enabled and allowed to settle, then every
// receiver port i is selected in turn and 2^NAVG_LOG2 samples are averaged
// into one result S[i,j]. Results leave column-major over a valid/ready
// handshake.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start        pulse: begin a sweep (ignored while busy)
//   abort        return to IDLE at once, discarding the current entry
//   busy         high whenever the controller is not IDLE
//   done         one-cycle pulse when the last result has been accepted
//   bus          master side of sparam_sweep_ctrl_if (excitation, receiver
//                select, sample input, result handshake)
// ---------------------------------------------------------------------------
module sparam_sweep_ctrl #(
    parameter int NPORTS    = 3,
    parameter int SETTLE    = 16,
    parameter int NAVG_LOG2 = 3,
    parameter int DW        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    sparam_sweep_ctrl_if.master bus
);
    // Accumulator is wide enough to hold 2^NAVG_LOG2 full-scale samples.
    localparam int AW = DW + NAVG_LOG2;
    localparam int CW = NAVG_LOG2 + 1;
    localparam logic [CW-1:0] LAST_SAMPLE = CW'((1 << NAVG_LOG2) - 1);
    localparam logic [1:0]    LAST_IDX    = 2'(NPORTS - 1);
    // Loading SETTLE-1 and exiting on zero gives exactly SETTLE settle cycles.
    localparam logic [7:0]    SETTLE_LOAD = 8'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACQ,
        ST_EMIT,
        ST_FINISH
    } state_t;

    state_t        state_reg;
    logic [1:0]    row_reg;          // receiver index i
    logic [1:0]    col_reg;          // excitation index j
    logic [7:0]    settle_cnt_reg;
    logic [CW-1:0] sample_cnt_reg;
    logic [AW-1:0] acc_reg;
    logic          done_reg;
    logic          exc_en_reg;
    logic          res_valid_reg;
    logic [1:0]    res_row_reg;
    logic [1:0]    res_col_reg;
    logic [DW-1:0] res_data_reg;

    logic [AW-1:0] acc_next;

    always_comb begin
        acc_next = acc_reg + AW'(bus.rx_data);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            row_reg        <= '0;
            col_reg        <= '0;
            settle_cnt_reg <= '0;
            sample_cnt_reg <= '0;
            acc_reg        <= '0;
            done_reg       <= 1'b0;
            exc_en_reg     <= 1'b0;
            res_valid_reg  <= 1'b0;
            res_row_reg    <= '0;
            res_col_reg    <= '0;
            res_data_reg   <= '0;
        end else begin
            done_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg      <= ST_SETTLE;
                        row_reg        <= '0;
                        col_reg        <= '0;
                        exc_en_reg     <= 1'b1;
                        settle_cnt_reg <= SETTLE_LOAD;
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt_reg == '0) begin
                        state_reg      <= ST_ACQ;
                        acc_reg        <= '0;
                        sample_cnt_reg <= '0;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg - 8'd1;
                    end
                end

                ST_ACQ: begin
                    if (bus.rx_valid) begin
                        acc_reg <= acc_next;
                        if (sample_cnt_reg == LAST_SAMPLE) begin
                            // The strobe completing the count is included in
                            // the average, so use acc_next rather than acc_reg.
                            state_reg     <= ST_EMIT;
                            res_valid_reg <= 1'b1;
                            res_data_reg  <= acc_next[AW-1:NAVG_LOG2];
                            res_row_reg   <= row_reg;
                            res_col_reg   <= col_reg;
                        end else begin
                            sample_cnt_reg <= sample_cnt_reg + CW'(1);
                        end
                    end
                end

                ST_EMIT: begin
                    if (bus.res_ready) begin
                        res_valid_reg <= 1'b0;
                        if (row_reg != LAST_IDX) begin
                            // Same excitation, next receiver: source already
                            // settled, go straight back to acquisition.
                            state_reg      <= ST_ACQ;
                            row_reg        <= row_reg + 2'd1;
                            acc_reg        <= '0;
                            sample_cnt_reg <= '0;
                        end else if (col_reg != LAST_IDX) begin
                            state_reg      <= ST_SETTLE;
                            row_reg        <= '0;
                            col_reg        <= col_reg + 2'd1;
                            settle_cnt_reg <= SETTLE_LOAD;
                        end else begin
                            state_reg  <= ST_FINISH;
                            exc_en_reg <= 1'b0;
                            done_reg   <= 1'b1;
                        end
                    end
                end

                ST_FINISH: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            // Abort wins over every transition above, including a handshake
            // that would otherwise have completed the sweep.
            if (abort && (state_reg != ST_IDLE)) begin
                state_reg      <= ST_IDLE;
                exc_en_reg     <= 1'b0;
                res_valid_reg  <= 1'b0;
                done_reg       <= 1'b0;
                acc_reg        <= '0;
                sample_cnt_reg <= '0;
                settle_cnt_reg <= '0;
            end
        end
    end

    assign busy          = (state_reg != ST_IDLE);
    assign done          = done_reg;
    assign bus.exc_en    = exc_en_reg;
    assign bus.exc_port  = col_reg;
    assign bus.rx_sel    = row_reg;
    assign bus.res_valid = res_valid_reg;
    assign bus.res_row   = res_row_reg;
    assign bus.res_col   = res_col_reg;
    assign bus.res_data  = res_data_reg;

endmodule

// File: tb/tb_sparam_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sparam_sweep_ctrl
// Directed bench for sparam_sweep_ctrl with NPORTS=3, SETTLE=4, NAVG_LOG2=2,
// DW=8. Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_sparam_sweep_ctrl;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic abort;
    logic busy;
    logic done;

    sparam_sweep_ctrl_if #(.DW(DW)) bus ();

    sparam_sweep_ctrl #(
        .NPORTS    (3),
        .SETTLE    (4),
        .NAVG_LOG2 (2),
        .DW        (DW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] d);
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        step();
    endtask

    task automatic handshake();
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_exc"},   32'(bus.exc_en), 0);
        chk({tag, "_port"},  32'(bus.exc_port), 0);
        chk({tag, "_rxsel"}, 32'(bus.rx_sel), 0);
        chk({tag, "_valid"}, 32'(bus.res_valid), 0);
        chk({tag, "_row"},   32'(bus.res_row), 0);
        chk({tag, "_col"},   32'(bus.res_col), 0);
        chk({tag, "_data"},  32'(bus.res_data), 0);
    endtask

    int k;
    int dcnt;
    int row;
    int col;
    bit fin;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        bus.rx_valid = 1'b0; bus.rx_data = '0; bus.res_ready = 1'b0;
        step(); step();
        chk_all_zero("reset");
        rst = 1'b0;
        bus.res_ready = 1'b1;   // ready with nothing valid must be harmless
        step();
        bus.res_ready = 1'b0;
        chk("idle_busy", 32'(busy), 0);

        // Sweep 1: settle masking, truncation, backpressure.
        start = 1'b1; step(); start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_exc", 32'(bus.exc_en), 1);
        chk("start_port", 32'(bus.exc_port), 0);
        chk("start_rxsel", 32'(bus.rx_sel), 0);
        repeat (4) feed(8'd200);            // strobes during settle, ignored
        feed(8'd255); feed(8'd255); feed(8'd255); feed(8'd254);
        bus.rx_valid = 1'b0;
        chk("s00_valid", 32'(bus.res_valid), 1);
        chk("s00_data", 32'(bus.res_data), 254);
        chk("s00_row", 32'(bus.res_row), 0);
        chk("s00_col", 32'(bus.res_col), 0);

        bus.rx_valid = 1'b1; bus.rx_data = 8'd77;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("bp_valid", 32'(bus.res_valid), 1);
            chk("bp_data", 32'(bus.res_data), 254);
            chk("bp_row", 32'(bus.res_row), 0);
            chk("bp_col", 32'(bus.res_col), 0);
        end
        bus.rx_valid = 1'b0;
        handshake();
        chk("hs_valid", 32'(bus.res_valid), 0);
        chk("hs_rxsel", 32'(bus.rx_sel), 1);
        chk("hs_port", 32'(bus.exc_port), 0);

        feed(8'd1); feed(8'd2); feed(8'd2); feed(8'd2);
        bus.rx_valid = 1'b0;
        chk("s10_valid", 32'(bus.res_valid), 1);
        chk("s10_data", 32'(bus.res_data), 1);
        chk("s10_row", 32'(bus.res_row), 1);
        chk("s10_col", 32'(bus.res_col), 0);
        handshake();

        repeat (4) feed(8'd40);
        bus.rx_valid = 1'b0;
        chk("s20_data", 32'(bus.res_data), 40);
        chk("s20_row", 32'(bus.res_row), 2);
        handshake();
        chk("col1_port", 32'(bus.exc_port), 1);
        chk("col1_rxsel", 32'(bus.rx_sel), 0);
        chk("col1_valid", 32'(bus.res_valid), 0);

        repeat (4) feed(8'd255);            // settle after port change
        repeat (4) feed(8'd8);
        bus.rx_valid = 1'b0;
        chk("s01_data", 32'(bus.res_data), 8);
        chk("s01_row", 32'(bus.res_row), 0);
        chk("s01_col", 32'(bus.res_col), 1);

        start = 1'b1; step(); start = 1'b0;  // start while busy
        chk("ign_valid", 32'(bus.res_valid), 1);
        chk("ign_row", 32'(bus.res_row), 0);
        chk("ign_col", 32'(bus.res_col), 1);
        chk("ign_port", 32'(bus.exc_port), 1);
        handshake();
        chk("s11_rxsel", 32'(bus.rx_sel), 1);
        feed(8'd50); feed(8'd50);
        bus.rx_valid = 1'b0;

        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_exc", 32'(bus.exc_en), 0);
        chk("abort_valid", 32'(bus.res_valid), 0);
        chk("abort_done", 32'(done), 0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("abort_nodone", 32'(done), 0);
        end

        // Restart goes back to S[0,0].
        start = 1'b1; step(); start = 1'b0;
        chk("re_busy", 32'(busy), 1);
        chk("re_port", 32'(bus.exc_port), 0);
        chk("re_rxsel", 32'(bus.rx_sel), 0);
        repeat (4) step();
        repeat (4) feed(8'd9);
        bus.rx_valid = 1'b0;
        chk("re_valid", 32'(bus.res_valid), 1);
        chk("re_data", 32'(bus.res_data), 9);
        chk("re_row", 32'(bus.res_row), 0);
        chk("re_col", 32'(bus.res_col), 0);

        // Reset while in EMIT.
        rst = 1'b1; step(); rst = 1'b0;
        chk_all_zero("emit_rst");

        // Full free-running sweep, rx_data = 10*(i+1)+j.
        bus.res_ready = 1'b1; bus.rx_valid = 1'b1;
        bus.rx_data = 8'd10;
        start = 1'b1; step(); start = 1'b0;
        k = 0; dcnt = 0; fin = 1'b0;
        for (int c = 0; c < 300 && !fin; c++) begin
            bus.rx_data = 8'(10 * (int'(bus.rx_sel) + 1) + int'(bus.exc_port));
            step();
            if (bus.res_valid) begin
                row = k % 3;
                col = k / 3;
                chk("sweep_row", 32'(bus.res_row), 32'(row));
                chk("sweep_col", 32'(bus.res_col), 32'(col));
                chk("sweep_data", 32'(bus.res_data), 32'(10 * (row + 1) + col));
                k++;
            end
            if (done) begin
                dcnt++;
                chk("done_exc", 32'(bus.exc_en), 0);
                fin = 1'b1;
            end
        end
        chk("sweep_count", 32'(k), 9);
        chk("done_count", 32'(dcnt), 1);
        step();
        chk("post_done", 32'(done), 0);
        chk("post_busy", 32'(busy), 0);
        chk("post_exc", 32'(bus.exc_en), 0);
        bus.rx_valid = 1'b0; bus.res_ready = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
